// File: rtl/proc_clk_seq.sv
// Processor clock sequencer: startup delay, run/halt/single-step control of the
// clk_div8 gate enable, which only ever changes just after clk_div8 falls.
module proc_clk_seq #(
    parameter int STARTUP_PERIODS = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk_in,
    input  logic             rst_async_n,
    input  logic             clk_div8,
    input  logic             rst_sync_n,
    input  logic             halt_req,
    input  logic             resume_req,
    input  logic             step_req,
    output logic             en_clk_div8,
    output logic             running,
    output logic             halted,
    output logic             step_done,
    output logic [CNT_W-1:0] period_cnt
);

    typedef enum logic [2:0] {IDLE, STARTUP, RUN, HALTED, STEP} state_t;

    localparam logic [3:0]       START_LD = 4'(STARTUP_PERIODS);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic       div8_q;
    logic       rs_meta;
    logic       rs_s;
    logic       pend_resume;
    logic       pend_step;
    logic [3:0] startup_cnt;
    logic       commit;

    // Falling edge of clk_div8 seen: it now stays low for 3 more clk_in edges,
    // so switching the gate enable here cannot chop a high phase.
    assign commit = div8_q & ~clk_div8;

    always_ff @(posedge clk_in or negedge rst_async_n) begin
        if (!rst_async_n) begin
            div8_q  <= 1'b0;
            rs_meta <= 1'b0;
            rs_s    <= 1'b0;
        end else begin
            div8_q  <= clk_div8;
            rs_meta <= rst_sync_n;
            rs_s    <= rs_meta;
        end
    end

    always_ff @(posedge clk_in or negedge rst_async_n) begin
        if (!rst_async_n) begin
            period_cnt <= '0;
        end else if (commit && en_clk_div8) begin
            period_cnt <= period_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state       <= IDLE;
            en_clk_div8 <= 1'b0;
            running     <= 1'b0;
            halted      <= 1'b0;
            step_done   <= 1'b0;
            pend_resume <= 1'b0;
            pend_step   <= 1'b0;
            startup_cnt <= START_LD;
        end else begin
            step_done <= 1'b0;
            if (!rs_s) begin
                // Manager reset overrides everything without waiting for a commit edge.
                state       <= IDLE;
                en_clk_div8 <= 1'b0;
                running     <= 1'b0;
                halted      <= 1'b0;
                pend_resume <= 1'b0;
                pend_step   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        en_clk_div8 <= 1'b0;
                        startup_cnt <= START_LD;
                        state       <= STARTUP;
                    end
                    STARTUP: begin
                        if (commit) begin
                            if (startup_cnt == 4'd1) begin
                                if (halt_req) begin
                                    state  <= HALTED;
                                    halted <= 1'b1;
                                end else begin
                                    state       <= RUN;
                                    en_clk_div8 <= 1'b1;
                                    running     <= 1'b1;
                                end
                            end
                            startup_cnt <= startup_cnt - 4'd1;
                        end
                    end
                    RUN: begin
                        if (commit && halt_req) begin
                            state       <= HALTED;
                            en_clk_div8 <= 1'b0;
                            running     <= 1'b0;
                            halted      <= 1'b1;
                        end
                    end
                    HALTED: begin
                        if (commit && pend_resume) begin
                            state       <= RUN;
                            en_clk_div8 <= 1'b1;
                            running     <= 1'b1;
                            halted      <= 1'b0;
                            pend_resume <= 1'b0;
                            pend_step   <= 1'b0;
                        end else if (commit && pend_step) begin
                            state       <= STEP;
                            en_clk_div8 <= 1'b1;
                            halted      <= 1'b0;
                            pend_step   <= 1'b0;
                        end else if (resume_req) begin
                            pend_resume <= 1'b1;
                            pend_step   <= 1'b0;
                        end else if (step_req && !pend_resume) begin
                            pend_step <= 1'b1;
                        end
                    end
                    STEP: begin
                        if (commit) begin
                            state       <= HALTED;
                            en_clk_div8 <= 1'b0;
                            halted      <= 1'b1;
                            step_done   <= 1'b1;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        en_clk_div8 <= 1'b0;
                        running     <= 1'b0;
                        halted      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/proc_clk_seq.md
PROC_CLK_SEQ -- requirements
Module: proc_clk_seq

Interface
REQ-001 SHALL have parameter STARTUP_PERIODS, default 4, number of clk_div8 periods to wait after reset release before first enable (range 1-15).
REQ-002 SHALL have parameter CNT_W, default 16, width of the enabled-period counter.
REQ-003 SHALL have port clk_in  input  1  system clock, all state on posedge.
REQ-004 SHALL have port rst_async_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clk_div8  input  1  divide-by-8 clock from the clock/reset manager, sampled as data in clk_in domain.
REQ-006 SHALL have port rst_sync_n  input  1  manager's synchronised reset, clk_div8 domain, active-low.
REQ-007 SHALL have port halt_req  input  1  level; request processor clock stop.
REQ-008 SHALL have port resume_req  input  1  single-cycle pulse; leave HALTED.
REQ-009 SHALL have port step_req  input  1  single-cycle pulse; run one clk_div8 period from HALTED.
REQ-010 SHALL have port en_clk_div8  output  1  registered enable to the manager's processor clock gate.
REQ-011 SHALL have port running  output  1  high in RUN.
REQ-012 SHALL have port halted  output  1  high in HALTED.
REQ-013 SHALL have port step_done  output  1  one-clk_in-cycle pulse at the end of a step.
REQ-014 SHALL have port period_cnt  output  CNT_W  count of enabled clk_div8 periods.

Function
REQ-015 SHALL register clk_div8 into div8_q; a "commit edge" is a clk_in edge with div8_q==1 and clk_div8==0.
REQ-016 SHALL change en_clk_div8 only on commit edges (glitch-free gating: clk_div8 stays low for 3 further clk_in edges).
REQ-017 SHALL pass rst_sync_n through a 2-flop synchroniser to clk_in (rs_s); 2-cycle latency.
REQ-018 SHALL implement states IDLE, STARTUP, RUN, HALTED, STEP.
REQ-019 IDLE: en=0; go to STARTUP when rs_s==1; load startup counter with STARTUP_PERIODS.
REQ-020 STARTUP: decrement startup counter on each commit edge; on commit edge with counter==1, set en=1 and enter RUN, unless halt_req==1, then enter HALTED with en=0.
REQ-021 RUN: on commit edge with halt_req==1, clear en and enter HALTED; halt_req deasserted before a commit edge SHALL be ignored.
REQ-022 HALTED: resume_req latched into pending flag; on next commit edge with flag set, set en=1, enter RUN, clear flag.
REQ-023 HALTED: step_req latched into pending flag when no resume pending; on next commit edge, set en=1, enter STEP.
REQ-024 STEP: on the next commit edge, clear en, enter HALTED, pulse step_done for that cycle; exactly one clk_div8 high phase is enabled.
REQ-025 Simultaneous resume_req and step_req, or step pending when resume arrives: resume SHALL win, step flag cleared.
REQ-026 step_req/resume_req outside HALTED SHALL be ignored and not latched.
REQ-027 rs_s==0 in any state SHALL force IDLE, en=0, clear pending flags on the next clk_in edge (no commit-edge wait).
REQ-028 period_cnt SHALL increment by 1 on every commit edge at which en_clk_div8 is 1 (before update); wraps 2^CNT_W-1 -> 0.
REQ-029 running/halted/step_done SHALL be registered outputs decoded from state.

Reset
REQ-030 rst_async_n==0 SHALL asynchronously set: state IDLE, en_clk_div8=0, running=0, halted=0, step_done=0, period_cnt=0, div8_q=0, synchroniser flops=0, pending flags=0, startup counter=STARTUP_PERIODS.
REQ-031 After rst_async_n release, block SHALL stay IDLE until rs_s==1.

Verification
REQ-032 Reset release, default params, no requests -> en rises on 4th commit edge after rs_s==1; running=1; period_cnt increments every 8 clk_in cycles.
REQ-033 halt_req held in RUN -> en falls only on a commit edge, never while clk_div8==1; halted=1; period_cnt frozen.
REQ-034 In HALTED, step_req pulse -> exactly one clk_div8_proc high pulse (4 clk_in cycles), step_done one pulse, period_cnt +1, back in HALTED.
REQ-035 resume_req and step_req same cycle in HALTED -> RUN, no step_done.
REQ-036 Preload period_cnt to 0xFFFF via run time -> next enabled commit edge gives 0x0000.
REQ-037 rst_async_n asserted mid-STEP -> en=0 immediately, all outputs at reset values; restart follows REQ-032.
